axis_tx_pattern_gen: RTL and testbench
======================================

AXIS_TX_PATTERN_GEN -- requirements
Module: axis_tx_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXIS data width in bits; multiple of 8, 32..512; KW = DATA_WIDTH/8.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of frame byte length.
REQ-003 SHALL have parameter GAP_WIDTH, default 8, width of inter-frame gap count.
REQ-004 SHALL have parameter EST_STATE, default 4'b0011, TCP state code meaning ESTABLISHED.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: s_aclk, input, 1, clock; s_aresetn, input, 1, reset, active low, asynchronous.
REQ-006 SHALL have ports s_axis_tvalid out 1; s_axis_tready in 1; s_axis_tdata out DATA_WIDTH; s_axis_tkeep out KW; s_axis_tlast out 1. These form the AXIS master toward the TCP core.
REQ-007 SHALL have ports tx_packet_start_signal in 1, run request pulse; stop in 1, graceful stop request; tcp_state_out in 4, TCP core state.
REQ-008 SHALL have ports cfg_mode in 2, data pattern; cfg_frame_bytes in LEN_WIDTH; cfg_frame_count in 16, 0 = unlimited; cfg_gap in GAP_WIDTH, idle cycles between frames.
REQ-009 SHALL have ports busy out 1; done out 1, one-cycle pulse; frames_sent out 32.

Function
REQ-010 SHALL implement FSM IDLE, SEND, GAP; busy = (state != IDLE).
REQ-011 IDLE->SEND SHALL occur when tx_packet_start_signal=1, tcp_state_out==EST_STATE and cfg_frame_bytes!=0 are all true in the same cycle.
REQ-012 On that transition, the block SHALL latch all cfg_* inputs, clear frames_sent and the beat counter, and seed the LFSR to 32'hFFFFFFFF.
REQ-013 The start is sampled in cycle N; first s_axis_tvalid=1 SHALL appear in cycle N+1.
REQ-014 Start requests while busy, or while start conditions are unmet, SHALL be ignored.
REQ-015 In SEND, s_axis_tvalid SHALL be 1; a beat is accepted only when tvalid&&tready; tdata/tkeep/tlast SHALL hold stable until acceptance.
REQ-016 Beats per frame SHALL be ceil(bytes/KW); non-last beats have tkeep all ones. The last beat has tkeep with the low (bytes mod KW) bits set, or all ones if the remainder is 0. tlast=1 only on the last beat.
REQ-017 Data byte lanes with tkeep=0 SHALL be driven 0.
REQ-018 Mode 0 (counter): tdata SHALL equal a 64-bit accepted-beat counter, zero-extended or truncated to DATA_WIDTH. The counter continues across frames and wraps at 2^64.
REQ-019 Mode 1 (byte index): byte lane k of beat b SHALL equal (b*KW+k) mod 256; b restarts at 0 each frame; lane 0 = tdata[7:0].
REQ-020 Mode 2 (PRBS): tdata SHALL be the 32-bit LFSR (x^32+x^22+x^2+x+1, Galois) replicated across the width. The LFSR advances once per accepted beat.
REQ-021 Mode 3 SHALL behave as mode 0.
REQ-022 On an accepted tlast beat, frames_sent SHALL increment, wrapping at 2^32.
REQ-023 After that tlast beat, if cfg_frame_count!=0 and the new frames_sent equals it, the block SHALL go to IDLE with done=1 for one cycle.
REQ-024 Otherwise, if cfg_gap==0, the block SHALL stay in SEND and present the next frame's first beat the following cycle, with tvalid held high.
REQ-025 Otherwise, the block SHALL go to GAP with tvalid=0 for exactly cfg_gap cycles, then return to SEND.
REQ-026 stop=1 or tcp_state_out!=EST_STATE seen during SEND SHALL be latched as a pending stop. The current frame SHALL complete through tlast; no truncation, no tvalid drop. The block then goes to IDLE with done pulsed.
REQ-027 The same conditions during GAP SHALL cause an immediate move to IDLE with done pulsed.
REQ-028 If a stop and a frame_count completion coincide on the same tlast, the block SHALL produce exactly one done pulse.
REQ-029 In IDLE, s_axis_tvalid, s_axis_tlast and s_axis_tkeep SHALL be 0, and s_axis_tdata SHALL be 0.

Reset
REQ-030 s_aresetn=0 SHALL immediately force state=IDLE, all outputs 0, frames_sent=0, counters 0, LFSR=32'hFFFFFFFF, pending stop cleared.
REQ-031 Reset asserted mid-frame SHALL abandon the frame, with no tlast emitted. Deassertion is synchronous to s_aclk; the first start is accepted no earlier than the second edge after release.

Verification
REQ-032 DATA_WIDTH=64, mode 0, bytes=20, count=2, gap=0, tready=1 -> 6 consecutive beats, tdata 0..5. tkeep FF,FF,0F on each frame; tlast on beats 3 and 6. done pulses once; frames_sent=2.
REQ-033 Same config with tready pattern 1,0,0,1,0,1... -> no tdata/tkeep/tlast change while tready=0; the accepted sequence equals REQ-032.
REQ-034 Mode 1, bytes=9, gap=3, count=0 -> beat0 tdata=64'h0706050403020100, tkeep FF. Beat1 tdata=64'h08, tkeep 01, tlast. Exactly 3 tvalid=0 cycles before the next frame.
REQ-035 Mode 2, bytes=64 -> beat0 tdata=64'hFFFFFFFF_FFFFFFFF; each later beat is the LFSR step of the previous one.
REQ-036 tcp_state_out changes to 4'b0100 on beat 2 of an 8-beat frame -> beats 3..8 still sent and tlast delivered. Then IDLE, one done pulse, and a start in the next cycle is ignored.
REQ-037 s_aresetn pulsed low during beat 4 -> outputs 0 in the same cycle, frames_sent=0, busy=0; a fresh start restarts counter data at 0.

Source files
------------

// File: rtl/axis_tx_pattern_gen.sv
// AXI-Stream frame pattern generator feeding the TCP core TX path.
// Emits frames of a configured byte length with counter, byte-index or
// PRBS payload, separated by an optional idle gap, until the frame count
// is reached or a graceful stop is requested.

module axis_tx_pattern_lane (
   input  logic [1:0] mode,
   input  logic       keep,
   input  logic [7:0] cnt_byte,
   input  logic [7:0] idx_byte,
   input  logic [7:0] prbs_byte,
   output logic [7:0] data
);
   // Pick this lane's pattern byte; lanes outside tkeep are driven to zero
   always_comb begin
      data = 8'h00;
      if (keep) begin
         case (mode)
            2'd1:    data = idx_byte;
            2'd2:    data = prbs_byte;
            default: data = cnt_byte;
         endcase
      end
   end
endmodule

module axis_tx_pattern_gen #(
   parameter int         DATA_WIDTH = 64,
   parameter int         LEN_WIDTH  = 16,
   parameter int         GAP_WIDTH  = 8,
   parameter logic [3:0] EST_STATE  = 4'b0011
) (
   input  logic                    s_aclk,
   input  logic                    s_aresetn,
   output logic                    s_axis_tvalid,
   input  logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   s_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   output logic                    s_axis_tlast,
   input  logic                    tx_packet_start_signal,
   input  logic                    stop,
   input  logic [3:0]              tcp_state_out,
   input  logic [1:0]              cfg_mode,
   input  logic [LEN_WIDTH-1:0]    cfg_frame_bytes,
   input  logic [15:0]             cfg_frame_count,
   input  logic [GAP_WIDTH-1:0]    cfg_gap,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             frames_sent
);
   localparam int                   KW         = DATA_WIDTH / 8;
   localparam logic [LEN_WIDTH-1:0] KW_L       = LEN_WIDTH'(KW);
   localparam logic [31:0]          LFSR_TAPS  = 32'h8020_0003;
   localparam logic [31:0]          LFSR_SEED  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   typedef struct packed {
      logic [1:0]           mode;
      logic [15:0]          count;
      logic [GAP_WIDTH-1:0] gap;
   } cfg_t;

   state_t                 state, state_n;
   logic                   done_n;
   logic                   rst_arm;
   cfg_t                   cfg_q;
   logic [LEN_WIDTH-1:0]   last_idx, beat_idx;
   logic [KW-1:0]          last_keep;
   logic [63:0]            beat_cnt;
   logic [7:0]             idx_base;
   logic [31:0]            lfsr, lfsr_step;
   logic [GAP_WIDTH-1:0]   gap_cnt;
   logic                   stop_pend;

   logic                   start_ok, stop_req, accept, last_beat, count_hit;
   logic [31:0]            frames_inc;
   logic [LEN_WIDTH-1:0]   start_rem, start_last_idx;
   logic [KW-1:0]          start_keep;
   logic [DATA_WIDTH-1:0]  cnt_ext;

   // rst_arm holds off the first edge after reset release so a start
   // cannot be taken on that edge
   assign start_ok   = rst_arm && tx_packet_start_signal &&
                       (tcp_state_out == EST_STATE) && (cfg_frame_bytes != '0);
   assign stop_req   = stop || (tcp_state_out != EST_STATE);
   assign accept     = (state == SEND) && s_axis_tready;
   assign last_beat  = (beat_idx == last_idx);
   assign frames_inc = frames_sent + 32'd1;
   assign count_hit  = (cfg_q.count != 16'd0) && (frames_inc == {16'd0, cfg_q.count});
   // Galois LFSR, right-shifting form of x^32+x^22+x^2+x+1
   assign lfsr_step  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
   assign cnt_ext    = DATA_WIDTH'(beat_cnt);

   // Frame geometry derived once from the configured byte length at start
   always_comb begin
      start_rem      = cfg_frame_bytes % KW_L;
      start_last_idx = (cfg_frame_bytes - LEN_WIDTH'(1)) / KW_L;
      start_keep     = '0;
      for (int k = 0; k < KW; k++)
         start_keep[k] = (start_rem == '0) || (LEN_WIDTH'(k) < start_rem);
   end

   // State register, done pulse and post-reset start arming
   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         state   <= IDLE;
         done    <= 1'b0;
         rst_arm <= 1'b0;
      end else begin
         state   <= state_n;
         done    <= done_n;
         rst_arm <= 1'b1;
      end
   end

   // Next-state logic; a stop during a frame waits for tlast, in GAP it is immediate
   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      case (state)
         IDLE: if (start_ok) state_n = SEND;
         SEND: begin
            if (accept && last_beat) begin
               if (count_hit || stop_pend || stop_req) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else if (cfg_q.gap != '0) begin
                  state_n = GAP;
               end
            end
         end
         GAP: begin
            if (stop_req) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else if (gap_cnt == cfg_q.gap - GAP_WIDTH'(1)) begin
               state_n = SEND;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath: config latch, beat/frame counters, LFSR and pending stop
   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         cfg_q       <= '0;
         last_idx    <= '0;
         last_keep   <= '0;
         beat_idx    <= '0;
         beat_cnt    <= '0;
         idx_base    <= '0;
         lfsr        <= LFSR_SEED;
         frames_sent <= '0;
         stop_pend   <= 1'b0;
         gap_cnt     <= '0;
      end else begin
         if (state == IDLE && start_ok) begin
            cfg_q       <= '{mode: cfg_mode, count: cfg_frame_count, gap: cfg_gap};
            last_idx    <= start_last_idx;
            last_keep   <= start_keep;
            beat_idx    <= '0;
            beat_cnt    <= '0;
            idx_base    <= '0;
            lfsr        <= LFSR_SEED;
            frames_sent <= '0;
            stop_pend   <= 1'b0;
         end else begin
            if (accept) begin
               beat_cnt <= beat_cnt + 64'd1;
               lfsr     <= lfsr_step;
               if (last_beat) begin
                  beat_idx    <= '0;
                  idx_base    <= '0;
                  frames_sent <= frames_inc;
               end else begin
                  beat_idx <= beat_idx + LEN_WIDTH'(1);
                  idx_base <= idx_base + 8'(KW);
               end
            end
            if (state == SEND && stop_req) stop_pend <= 1'b1;
         end
         gap_cnt <= (state == GAP) ? gap_cnt + GAP_WIDTH'(1) : '0;
      end
   end

   assign s_axis_tvalid = (state == SEND);
   assign s_axis_tlast  = (state == SEND) && last_beat;
   assign s_axis_tkeep  = (state == SEND) ? (last_beat ? last_keep : '1) : '0;
   assign busy          = (state != IDLE);

   for (genvar g = 0; g < KW; g++) begin : g_lane
      axis_tx_pattern_lane u_lane (
         .mode      (cfg_q.mode),
         .keep      (s_axis_tkeep[g]),
         .cnt_byte  (cnt_ext[8*g +: 8]),
         .idx_byte  (idx_base + 8'(g)),
         .prbs_byte (lfsr[(8*g)%32 +: 8]),
         .data      (s_axis_tdata[8*g +: 8])
      );
   end

endmodule

// File: tb/tb_axis_tx_pattern_gen.sv
// Scoreboard bench for axis_tx_pattern_gen (DATA_WIDTH=64).

module tb_axis_tx_pattern_gen;
   localparam logic [3:0] EST = 4'b0011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tvalid, tready, tlast;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        start, stop;
   logic [3:0]  tcp;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_bytes, cfg_count;
   logic [7:0]  cfg_gap;
   logic        busy, done;
   logic [31:0] frames_sent;

   always #5 clk = ~clk;

   axis_tx_pattern_gen #(.DATA_WIDTH(64), .LEN_WIDTH(16), .GAP_WIDTH(8), .EST_STATE(4'b0011)) dut (
      .s_aclk(clk), .s_aresetn(rst_n),
      .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
      .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
      .tx_packet_start_signal(start), .stop(stop), .tcp_state_out(tcp),
      .cfg_mode(cfg_mode), .cfg_frame_bytes(cfg_bytes), .cfg_frame_count(cfg_count),
      .cfg_gap(cfg_gap), .busy(busy), .done(done), .frames_sent(frames_sent)
   );

   typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
   beat_t exp_q[$];

   int n_checks = 0, n_fail = 0;
   int n_acc = 0, n_done = 0, last_gap = -1, gap_run = 0;
   logic in_gap = 1'b0, hold_chk = 1'b0, rdy_pat = 1'b0;
   logic [72:0] hold_val;
   int pat [6] = '{1, 0, 0, 1, 0, 1};

   logic [31:0] prbs_tab [8] = '{32'hFFFFFFFF, 32'hFFDFFFFC, 32'h7FEFFFFE, 32'h3FF7FFFF,
                                32'h9FDBFFFC, 32'h4FEDFFFE, 32'h27F6FFFF, 32'h93DB7FFC};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
      beat_t b;
      b.data = d; b.keep = k; b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic new_test();
      n_done = 0; n_acc = 0; last_gap = -1;
   endtask

   // Monitor: pops expectations on every accepted beat, checks stall stability and gaps
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         hold_chk = 1'b0;
         in_gap   = 1'b0;
      end else begin
         if (done) n_done++;
         if (hold_chk) check("stall_hold", 128'({tdata, tkeep, tlast}), 128'(hold_val));
         hold_chk = tvalid && !tready;
         hold_val = {tdata, tkeep, tlast};
         if (in_gap) begin
            if (!busy) in_gap = 1'b0;
            else if (tvalid) begin last_gap = gap_run; in_gap = 1'b0; end
            else gap_run++;
         end
         if (tvalid && tready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_beat: got data %h keep %h last %b, required no beat",
                        tdata, tkeep, tlast);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("beat%0d", n_acc), 128'({tdata, tkeep, tlast}),
                     128'({e.data, e.keep, e.last}));
            end
            if (tlast) begin in_gap = 1'b1; gap_run = 0; end
         end
      end
   end

   // tready driver: always ready, or the 1,0,0,1,0,1 back-pressure pattern
   initial begin
      int pi = 0;
      tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rdy_pat) begin tready = pat[pi % 6][0]; pi++; end
         else tready = 1'b1;
      end
   end

   task automatic start_run(input logic [1:0] m, input logic [15:0] b, input logic [15:0] c,
                            input logic [7:0] g);
      @(posedge clk); #1;
      cfg_mode = m; cfg_bytes = b; cfg_count = c; cfg_gap = g; start = 1'b1;
      check("idle_before_start", 128'(busy), 128'(0));
      @(posedge clk); #1;
      start = 1'b0;
      check("first_valid_next_cycle", 128'(tvalid), 128'(1));
   endtask

   task automatic start_ignored(input string nm, input logic [15:0] b, input logic [3:0] st);
      @(posedge clk); #1;
      cfg_mode = 2'd0; cfg_bytes = b; cfg_count = 16'd1; cfg_gap = 8'd0; tcp = st; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check(nm, 128'({busy, tvalid}), 128'(0));
      tcp = EST;
   endtask

   task automatic wait_idle(input int max);
      int i = 0;
      while (busy && i < max) begin @(negedge clk); #1; i++; end
      check("idle_within_bound", 128'(busy), 128'(0));
   endtask

   task automatic wait_acc(input int n);
      int i = 0;
      while (n_acc < n && i < 500) begin @(negedge clk); #1; i++; end
      check("beats_within_bound", 128'(n_acc >= n), 128'(1));
   endtask

   task automatic wait_frames(input logic [31:0] f, input logic need_valid);
      int i = 0;
      while (!(frames_sent == f && (tvalid || !need_valid)) && i < 500) begin
         @(negedge clk); #1; i++;
      end
      check("frames_within_bound", 128'(frames_sent), 128'(f));
   endtask

   task automatic push_cnt20();
      push(64'd0, 8'hFF, 1'b0); push(64'd1, 8'hFF, 1'b0); push(64'd2, 8'h0F, 1'b1);
      push(64'd3, 8'hFF, 1'b0); push(64'd4, 8'hFF, 1'b0); push(64'd5, 8'h0F, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; tcp = EST;
      cfg_mode = 2'd0; cfg_bytes = 16'd0; cfg_count = 16'd0; cfg_gap = 8'd0;
      #12;
      check("reset_outputs", 128'({tvalid, tdata, tkeep, tlast, busy, done, frames_sent}), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);

      // Counter mode, 2 frames of 20 bytes, back to back; a mid-run start is ignored
      new_test();
      push_cnt20();
      start_run(2'd0, 16'd20, 16'd2, 8'd0);
      wait_acc(2);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_idle(200);
      check("t1_done_count", 128'(n_done), 128'(1));
      check("t1_frames_sent", 128'(frames_sent), 128'(2));
      check("t1_gap_zero", 128'(last_gap), 128'(0));
      check("t1_queue_drained", 128'(exp_q.size()), 128'(0));

      // Same config under back-pressure
      new_test();
      push_cnt20();
      rdy_pat = 1'b1;
      start_run(2'd0, 16'd20, 16'd2, 8'd0);
      wait_idle(400);
      rdy_pat = 1'b0;
      check("t2_done_count", 128'(n_done), 128'(1));
      check("t2_frames_sent", 128'(frames_sent), 128'(2));
      check("t2_queue_drained", 128'(exp_q.size()), 128'(0));

      // Byte-index mode, 9 bytes, gap 3, unlimited; stop during frame 2 beat 0
      new_test();
      repeat (2) begin
         push(64'h0706050403020100, 8'hFF, 1'b0);
         push(64'h0000000000000008, 8'h01, 1'b1);
      end
      start_run(2'd1, 16'd9, 16'd0, 8'd3);
      wait_frames(32'd1, 1'b1);
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      wait_idle(200);
      check("t3_gap_cycles", 128'(last_gap), 128'(3));
      check("t3_done_count", 128'(n_done), 128'(1));
      check("t3_frames_sent", 128'(frames_sent), 128'(2));
      check("t3_queue_drained", 128'(exp_q.size()), 128'(0));

      // Stop while in the gap leaves immediately
      new_test();
      push(64'h0706050403020100, 8'hFF, 1'b0);
      push(64'h0000000000000008, 8'h01, 1'b1);
      start_run(2'd1, 16'd9, 16'd0, 8'd3);
      wait_frames(32'd1, 1'b0);
      check("t4_gap_valid_low", 128'(tvalid), 128'(0));
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      check("t4_idle_after_gap_stop", 128'(busy), 128'(0));
      @(negedge clk); #1;
      check("t4_done_count", 128'(n_done), 128'(1));
      check("t4_queue_drained", 128'(exp_q.size()), 128'(0));

      // PRBS mode, one 64-byte frame
      new_test();
      for (int i = 0; i < 8; i++) push({prbs_tab[i], prbs_tab[i]}, 8'hFF, i == 7);
      start_run(2'd2, 16'd64, 16'd1, 8'd0);
      wait_idle(200);
      check("t5_done_count", 128'(n_done), 128'(1));
      check("t5_queue_drained", 128'(exp_q.size()), 128'(0));

      // TCP state drops on beat 2 of an 8-beat frame: frame completes, then a start is ignored
      new_test();
      for (int i = 0; i < 8; i++) push(64'(i), 8'hFF, i == 7);
      start_run(2'd3, 16'd64, 16'd0, 8'd0);
      wait_acc(1);
      @(posedge clk); #1 tcp = 4'b0100;
      wait_idle(200);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("t6_start_ignored", 128'({busy, tvalid}), 128'(0));
      @(negedge clk); #1;
      check("t6_done_count", 128'(n_done), 128'(1));
      check("t6_frames_sent", 128'(frames_sent), 128'(1));
      check("t6_queue_drained", 128'(exp_q.size()), 128'(0));
      tcp = EST;

      // Starts with zero length or non-established state are ignored
      start_ignored("zero_len_ignored", 16'd0, EST);
      start_ignored("not_est_ignored", 16'd20, 4'b0001);

      // Reset during beat 4, then a fresh run restarts counter data at 0
      new_test();
      push(64'd0, 8'hFF, 1'b0); push(64'd1, 8'hFF, 1'b1); push(64'd2, 8'hFF, 1'b0);
      start_run(2'd0, 16'd16, 16'd0, 8'd0);
      wait_acc(3);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("t7_reset_outputs", 128'({tvalid, tdata, tkeep, tlast, busy}), 128'(0));
      check("t7_reset_frames", 128'(frames_sent), 128'(0));
      check("t7_queue_drained", 128'(exp_q.size()), 128'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk);
      new_test();
      push(64'd0, 8'hFF, 1'b0); push(64'd1, 8'hFF, 1'b0); push(64'd2, 8'h0F, 1'b1);
      start_run(2'd0, 16'd20, 16'd1, 8'd0);
      wait_idle(200);
      check("t7_restart_done", 128'(n_done), 128'(1));
      check("t7_restart_frames", 128'(frames_sent), 128'(1));
      check("t7_restart_drained", 128'(exp_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_checks++; n_fail++;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
